// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer: walks a synchronous config ROM and issues one 24-bit
// {slave,sub,data} write per entry to a byte-level I2C controller using the
// GO/END/ACK handshake. Supports WRITE, DELAY, END and NOP entries, bounded
// NACK retries, sticky done/error status and software re-run.
module i2c_cfg_sequencer #(
  parameter int CLK_FREQ   = 50000000,
  parameter int I2C_FREQ   = 20000,
  parameter int DEPTH      = 64,
  parameter int MAX_RETRY  = 3,
  parameter int AUTO_START = 1
) (
  input  logic                                   iCLK,
  input  logic                                   iRST_N,
  input  logic                                   i_start,
  output logic                                   o_tick,
  output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] o_tbl_addr,
  input  logic [25:0]                            i_tbl_data,
  output logic [23:0]                            o_i2c_data,
  output logic                                   o_i2c_go,
  input  logic                                   i_i2c_end,
  input  logic                                   i_i2c_ack,
  output logic                                   o_busy,
  output logic                                   o_done,
  output logic                                   o_error,
  output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] o_fail_index
);

  localparam int DIV = CLK_FREQ / I2C_FREQ;
  localparam int TW  = $clog2(DIV);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_DELAY = 2'b01;
  localparam logic [1:0] OP_END   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_WAIT_END, S_DELAY, S_NEXT, S_DONE
  } state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [AW-1:0] idx;
  logic [RW-1:0] retry_cnt;
  logic [15:0]   dly_cnt;
  logic [7:0]    ent_slave;
  logic [15:0]   ent_payload;
  logic          auto_pend;

  // Free-running controller clock-enable; pulses on the last count of each period.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign o_tick     = (tick_cnt == TICK_LAST);
  // The entry index register drives the ROM directly so data is valid in LATCH.
  assign o_tbl_addr = idx;

  // Sequencer FSM with all handshake and status outputs registered.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state        <= S_IDLE;
      idx          <= '0;
      retry_cnt    <= '0;
      dly_cnt      <= '0;
      ent_slave    <= '0;
      ent_payload  <= '0;
      auto_pend    <= (AUTO_START != 0);
      o_i2c_data   <= '0;
      o_i2c_go     <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_fail_index <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // A pending auto-start and a software start in the same cycle give one run.
          if (auto_pend || i_start) begin
            auto_pend <= 1'b0;
            o_done    <= 1'b0;
            o_error   <= 1'b0;
            o_busy    <= 1'b1;
            idx       <= '0;
            retry_cnt <= '0;
            state     <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          ent_slave   <= i_tbl_data[23:16];
          ent_payload <= i_tbl_data[15:0];
          case (i_tbl_data[25:24])
            OP_WRITE: state <= S_ISSUE;
            OP_DELAY: begin
              dly_cnt <= i_tbl_data[15:0];
              state   <= (i_tbl_data[15:0] == 16'd0) ? S_NEXT : S_DELAY;
            end
            OP_END:   state <= S_DONE;
            default:  state <= S_NEXT;
          endcase
        end
        S_ISSUE: begin
          // Raising GO only on a tick guarantees at least one tick of GO low
          // between consecutive transfers, including retries.
          if (o_tick) begin
            o_i2c_data <= {ent_slave, ent_payload};
            o_i2c_go   <= 1'b1;
            state      <= S_WAIT_END;
          end
        end
        S_WAIT_END: begin
          if (o_tick && i_i2c_end) begin
            o_i2c_go <= 1'b0;
            if (!i_i2c_ack) begin
              retry_cnt <= '0;
              state     <= S_NEXT;
            end else if (MAX_RETRY == 0 || retry_cnt < RETRY_LIM) begin
              // Saturate rather than wrap when retrying forever.
              if (retry_cnt != '1) retry_cnt <= retry_cnt + 1'b1;
              state <= S_ISSUE;
            end else begin
              o_error      <= 1'b1;
              o_fail_index <= idx;
              o_busy       <= 1'b0;
              state        <= S_IDLE;
            end
          end
        end
        S_DELAY: begin
          if (o_tick) begin
            dly_cnt <= dly_cnt - 16'd1;
            if (dly_cnt <= 16'd1) state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (idx == LAST_IDX) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_FETCH;
          end
        end
        S_DONE: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// tb_i2c_cfg_sequencer: drives the sequencer with a small ROM and a behavioural
// I2C controller; expected transfers are queued per run and compared as the
// controller accepts each GO.
module tb_i2c_cfg_sequencer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [23:0] data;
    logic        nack;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        tick;
  logic [1:0]  tbl_addr;
  logic [25:0] tbl_data = '0;
  logic [23:0] i2c_data;
  logic        go;
  logic        i2c_end = 1'b0;
  logic        i2c_ack = 1'b0;
  logic        busy, done, error;
  logic [1:0]  fail_index;

  logic [25:0] rom [DEPTH];

  exp_t sb[$];
  int   gap_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_run_xfer = 0;
  int   tick_count = 0;
  int   end_tick = 0;
  int   xfer_ticks = 0;
  bit   active = 1'b0;
  bit   cur_nack = 1'b0;

  i2c_cfg_sequencer #(
    .CLK_FREQ(40), .I2C_FREQ(10), .DEPTH(DEPTH), .MAX_RETRY(3), .AUTO_START(1)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .i_start(start), .o_tick(tick),
    .o_tbl_addr(tbl_addr), .i_tbl_data(tbl_data), .o_i2c_data(i2c_data),
    .o_i2c_go(go), .i_i2c_end(i2c_end), .i_i2c_ack(i2c_ack),
    .o_busy(busy), .o_done(done), .o_error(error), .o_fail_index(fail_index)
  );

  always #5 clk = ~clk;

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] ent(input logic [1:0] op, input logic [7:0] sl, input logic [15:0] pl);
    return {op, sl, pl};
  endfunction

  task automatic load(input logic [25:0] e0, input logic [25:0] e1, input logic [25:0] e2, input logic [25:0] e3);
    rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
  endtask

  task automatic push(input logic [23:0] d, input logic nack);
    exp_t e;
    e.data = d;
    e.nack = nack;
    sb.push_back(e);
  endtask

  task automatic begin_run();
    n_run_xfer = 0;
    gap_q.delete();
  endtask

  task automatic start_run();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_finish(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!busy && (done || error)) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_finish"}, {31'd0, ok}, 32'd1);
  endtask

  // Behavioural byte-level controller: takes GO on a tick, reports END after
  // three ticks with the planned ACK, drops END once GO falls.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        i2c_end = 1'b0; i2c_ack = 1'b0; active = 1'b0; xfer_ticks = 0;
      end else if (tick) begin
        tick_count++;
        if (!go) begin
          i2c_end = 1'b0;
          active  = 1'b0;
        end else if (!active && !i2c_end) begin
          active = 1'b1;
          xfer_ticks = 0;
          n_run_xfer++;
          gap_q.push_back(tick_count - end_tick);
          check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("xfer_data", {8'd0, i2c_data}, {8'd0, e.data});
            cur_nack = e.nack;
          end else begin
            cur_nack = 1'b0;
          end
          $display("xfer %0d data=%06h nack=%0b gap_ticks=%0d", n_run_xfer, i2c_data, cur_nack, tick_count - end_tick);
        end else if (active) begin
          if (xfer_ticks == 2) begin
            i2c_end  = 1'b1;
            i2c_ack  = cur_nack;
            active   = 1'b0;
            end_tick = tick_count;
          end else begin
            xfer_ticks++;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    // Reset state, with the auto-start table already loaded.
    load(ent(2'b00, 8'h34, 16'h001A), ent(2'b00, 8'h40, 16'h1500), ent(2'b10, 8'h00, 16'h0), ent(2'b11, 8'h00, 16'h0));
    repeat (3) @(posedge clk);
    #1;
    check("rst_go", {31'd0, go}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_tick", {31'd0, tick}, 32'd0);
    check("rst_addr", {30'd0, tbl_addr}, 32'd0);
    check("rst_fail_idx", {30'd0, fail_index}, 32'd0);
    check("rst_i2c_data", {8'd0, i2c_data}, 32'd0);

    // Run 1: auto-start after reset, two acked writes then END.
    begin_run();
    push(24'h34001A, 1'b0);
    push(24'h401500, 1'b0);
    rst_n = 1'b1;
    wait_finish("auto");
    check("auto_done", {31'd0, done}, 32'd1);
    check("auto_error", {31'd0, error}, 32'd0);
    check("auto_xfers", n_run_xfer, 32'd2);
    check("auto_sb_empty", sb.size(), 32'd0);
    if (gap_q.size() >= 2) check("plain_gap_short", {31'd0, gap_q[1] <= 4}, 32'd1);

    // Tick divider: exactly one pulse every four clocks.
    t0 = tick_count;
    repeat (40) @(posedge clk);
    check("tick_rate", tick_count - t0, 32'd10);

    // Run 2: entry 1 NACKed four times exhausts MAX_RETRY=3.
    load(ent(2'b00, 8'h34, 16'h0001), ent(2'b00, 8'h40, 16'h0002), ent(2'b00, 8'h48, 16'h0003), ent(2'b10, 8'h00, 16'h0));
    begin_run();
    push(24'h340001, 1'b0);
    repeat (4) push(24'h400002, 1'b1);
    start_run();
    wait_finish("nack");
    check("nack_error", {31'd0, error}, 32'd1);
    check("nack_fail_idx", {30'd0, fail_index}, 32'd1);
    check("nack_done", {31'd0, done}, 32'd0);
    check("nack_xfers", n_run_xfer, 32'd5);
    check("nack_sb_empty", sb.size(), 32'd0);
    repeat (30) @(posedge clk);

    // Run 3: two NACKs then ACK, sequence completes.
    begin_run();
    push(24'h340001, 1'b0);
    push(24'h400002, 1'b1);
    push(24'h400002, 1'b1);
    push(24'h400002, 1'b0);
    push(24'h480003, 1'b0);
    start_run();
    wait_finish("retry");
    check("retry_done", {31'd0, done}, 32'd1);
    check("retry_error", {31'd0, error}, 32'd0);
    check("retry_xfers", n_run_xfer, 32'd5);
    check("retry_sb_empty", sb.size(), 32'd0);
    repeat (30) @(posedge clk);

    // Run 4: DELAY of 5 ticks between two writes.
    load(ent(2'b00, 8'h34, 16'h0001), ent(2'b01, 8'h00, 16'd5), ent(2'b00, 8'h40, 16'h0002), ent(2'b10, 8'h00, 16'h0));
    begin_run();
    push(24'h340001, 1'b0);
    push(24'h400002, 1'b0);
    start_run();
    wait_finish("delay");
    check("delay_done", {31'd0, done}, 32'd1);
    check("delay_xfers", gap_q.size(), 32'd2);
    if (gap_q.size() >= 2) begin
      check("delay_min", {31'd0, gap_q[1] >= 5}, 32'd1);
      check("delay_max", {31'd0, gap_q[1] <= 9}, 32'd1);
    end
    repeat (30) @(posedge clk);

    // Run 5: four WRITEs and no END; finishes after the last index.
    load(ent(2'b00, 8'h10, 16'h0001), ent(2'b00, 8'h12, 16'h0002), ent(2'b00, 8'h14, 16'h0003), ent(2'b00, 8'h16, 16'h0004));
    begin_run();
    push(24'h100001, 1'b0);
    push(24'h120002, 1'b0);
    push(24'h140003, 1'b0);
    push(24'h160004, 1'b0);
    start_run();
    wait_finish("full");
    check("full_done", {31'd0, done}, 32'd1);
    check("full_xfers", n_run_xfer, 32'd4);
    check("full_addr_last", {30'd0, tbl_addr}, 32'd3);
    check("full_sb_empty", sb.size(), 32'd0);
    repeat (30) @(posedge clk);

    // Run 6: reset while a transfer is outstanding drops GO immediately.
    load(ent(2'b00, 8'h34, 16'h0001), ent(2'b00, 8'h40, 16'h0002), ent(2'b10, 8'h00, 16'h0), ent(2'b11, 8'h00, 16'h0));
    begin_run();
    push(24'h340001, 1'b0);
    push(24'h400002, 1'b0);
    start_run();
    for (int i = 0; i < 500 && n_run_xfer == 0; i++) @(posedge clk);
    check("mid_go_seen", {31'd0, go}, 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_go", {31'd0, go}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    sb.delete();
    repeat (3) @(posedge clk);

    // Release reset with a start pulse in the same cycle: exactly one run from index 0.
    begin_run();
    push(24'h340001, 1'b0);
    push(24'h400002, 1'b0);
    #1 rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rerun_busy", {31'd0, busy}, 32'd1);
    // A start pulse while busy must be ignored.
    start_run();
    wait_finish("rerun");
    check("rerun_done", {31'd0, done}, 32'd1);
    check("rerun_xfers", n_run_xfer, 32'd2);
    check("rerun_sb_empty", sb.size(), 32'd0);
    repeat (100) @(posedge clk);
    #1;
    check("rerun_idle", {31'd0, busy}, 32'd0);
    check("rerun_no_extra", n_run_xfer, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
